// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer between NUM_REQ byte-stream
// requesters. Arbitration is round-robin and packet-granular: the owner keeps
// the grant until its last byte has been handed over. Exactly one byte is in
// flight at a time. The controller launches a byte, waits for the uart to go
// busy, then waits for it to go idle again.
// Optional watchdog: define UART_TX_ARBITER_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT_CLKS = 2048
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [8*NUM_REQ-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]     i_req_last,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic                   o_tx_byte_rdy,
    output logic [7:0]             o_tx_byte,
    input  logic                   i_tx_busy,
    input  logic                   i_tx_done,
    output logic                   o_timeout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_ARB,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_IDLE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     owner;
    logic                 pkt_open;
    logic [NUM_REQ-1:0]   grant;
    logic [7:0]           tx_byte;

    logic [IDX_W-1:0]     winner;
    logic                 win_found;
    logic [IDX_W-1:0]     sel;
    logic [7:0]           sel_data;
    logic                 sel_last;
    logic [NUM_REQ-1:0]   sel_onehot;
    logic [NUM_REQ-1:0]   ready;
    logic                 accept;
    logic                 timeout_hit;

    // The uart done strobe is informational only; busy carries the handshake.
    logic                 unused_tx_done;
    assign unused_tx_done = i_tx_done;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    // Round-robin search: the first valid requester at or after ptr, with wrap.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        winner    = ptr;
        win_found = 1'b0;
        // Walk from the farthest offset down so the closest valid requester wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NUM_REQ;
            if (i_req_valid[idx]) begin
                winner    = IDX_W'(idx);
                win_found = 1'b1;
            end
        end
    end

    assign sel = pkt_open ? owner : winner;

    // Lane mux for the requester being served this cycle.
    always_comb begin
        sel_data   = 8'h00;
        sel_last   = 1'b0;
        sel_onehot = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (sel == IDX_W'(n)) begin
                sel_data      = i_req_data[8*n +: 8];
                sel_last      = i_req_last[n];
                sel_onehot[n] = 1'b1;
            end
        end
    end

    assign accept = |ready;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // Watchdog: restarts with every launch and counts while waiting on the uart.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wd_cnt <= '0;
        end else if (accept) begin
            wd_cnt <= '0;
        end else if (state == ST_WAIT_BUSY || state == ST_WAIT_IDLE) begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end

    assign timeout_hit = (state == ST_WAIT_BUSY || state == ST_WAIT_IDLE) &&
                         (wd_cnt == 16'(TIMEOUT_CLKS - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!i_rst_n) state <= ST_ARB;
        else          state <= state_nxt;
    end

    // Next-state logic: launch, wait for busy to rise, then for it to fall.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_ARB:       if (accept)          state_nxt = ST_LAUNCH;
            ST_LAUNCH:                         state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (timeout_hit)     state_nxt = ST_ARB;
                          else if (i_tx_busy)  state_nxt = ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (timeout_hit)     state_nxt = ST_ARB;
                          else if (!i_tx_busy) state_nxt = ST_ARB;
            default:                           state_nxt = ST_ARB;
        endcase
    end

    // Packet bookkeeping: capture the byte, owner, grant and pointer on accept.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr      <= '0;
            owner    <= '0;
            pkt_open <= 1'b0;
            grant    <= '0;
            tx_byte  <= 8'h00;
        end else if (accept) begin
            tx_byte  <= sel_data;
            owner    <= sel;
            grant    <= sel_onehot;
            pkt_open <= !sel_last;
            if (sel_last) ptr <= next_idx(sel);
        end else if (timeout_hit) begin
            pkt_open <= 1'b0;
            grant    <= '0;
            ptr      <= next_idx(owner);
        end else if (state == ST_WAIT_IDLE && !i_tx_busy && !pkt_open) begin
            grant    <= '0;
        end
    end

    // Outputs: ready only in arbitration with the uart idle, and only for the owner while a packet is open.
    always_comb begin
        ready = '0;
        if (state == ST_ARB && !i_tx_busy) begin
            if (pkt_open)       ready = sel_onehot & i_req_valid;
            else if (win_found) ready = sel_onehot;
        end
        o_req_ready   = ready;
        o_grant       = grant;
        o_tx_byte_rdy = (state == ST_LAUNCH);
        o_tx_byte     = tx_byte;
        o_timeout     = timeout_hit;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter. A small uart_tx stand-in raises busy
// for FRAME clocks after each launch and records every launched byte.
// The watchdog scenario runs only when UART_TX_ARBITER_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int FRAME = 10;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_byte_rdy;
    logic [7:0]     tx_byte;
    logic           tx_busy;
    logic           tx_done;
    logic           timeout;

    int n_assert = 0;
    int n_fail   = 0;
    int stray    = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CLKS(16)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .i_req_data    (req_data),
        .i_req_last    (req_last),
        .o_req_ready   (req_ready),
        .o_grant       (grant),
        .o_tx_byte_rdy (tx_byte_rdy),
        .o_tx_byte     (tx_byte),
        .i_tx_busy     (tx_busy),
        .i_tx_done     (tx_done),
        .o_timeout     (timeout)
    );

    // uart_tx stand-in: it has no reset, and it ignores launch strobes while busy.
    int         busy_cnt = 0;
    bit         model_en = 1'b1;
    logic [7:0] sent[$];

    always @(posedge clk) begin
        if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (model_en && tx_byte_rdy) begin
            busy_cnt <= FRAME;
            sent.push_back(tx_byte);
        end
    end

    assign tx_busy = (busy_cnt != 0);
    assign tx_done = (busy_cnt == 1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int idx, input logic [7:0] d, input logic l);
        req_data[idx*8 +: 8] = d;
        req_last[idx]        = l;
        req_valid[idx]       = 1'b1;
    endtask

    // Present one byte on lane idx and wait (bounded) until it is accepted.
    // Any ready seen on another lane while waiting is counted in stray.
    task automatic offer(input int idx, input logic [7:0] d, input logic l, output bit got);
        logic [N-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        set_lane(idx, d, l);
        #1;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if ((req_ready & ~mask) != '0) stray++;
            if (req_ready[idx]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        @(negedge clk); #1;
    endtask

    // Wait (bounded) until no packet is open and the uart is idle.
    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (grant == '0 && !tx_busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    // Wait (bounded) for any ready; report which lane and whether the uart was busy then.
    task automatic wait_any(output int idx, output bit busy_at);
        idx     = -1;
        busy_at = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (req_ready != '0) begin
                for (int j = 0; j < N; j++) if (req_ready[j]) idx = j;
                busy_at = tx_busy;
                break;
            end
            @(negedge clk); #1;
        end
        @(negedge clk); #1;
    endtask

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        bit got;
        bit ok;
        bit busy_at;
        int idx;
        int launches;
        int rdy_seen;

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset state.
        check("rst_ready",   32'(req_ready),   32'h0);
        check("rst_grant",   32'(grant),       32'h0);
        check("rst_byte_rdy", 32'(tx_byte_rdy), 32'h0);
        check("rst_tx_byte", 32'(tx_byte),     32'h00);
        check("rst_timeout", 32'(timeout),     32'h0);

        // Single-byte packet from req0.
        set_lane(0, 8'hA5, 1'b1);
        #1;
        check("t1_ready",       32'(req_ready), 32'h1);
        check("t1_grant_early", 32'(grant),     32'h0);
        @(negedge clk); #1;
        req_valid[0] = 1'b0;
        check("t1_launch",      32'(tx_byte_rdy), 32'h1);
        check("t1_byte",        32'(tx_byte),     32'hA5);
        check("t1_grant",       32'(grant),       32'h1);
        check("t1_ready_off",   32'(req_ready),   32'h0);
        @(negedge clk); #1;
        check("t1_launch_once", 32'(tx_byte_rdy), 32'h0);
        check("t1_byte_hold",   32'(tx_byte),     32'hA5);
        check("t1_grant_hold",  32'(grant),       32'h1);
        wait_idle(ok);
        check("t1_idle",        32'(ok),          32'h1);
        check("t1_sent_n",      32'(sent.size()), 32'd1);
        if (sent.size() >= 1) check("t1_sent0", 32'(sent[0]), 32'hA5);

        // Packet hold: req1 sends 11/22/33 while req2 waits with 44.
        sent.delete();
        stray = 0;
        set_lane(2, 8'h44, 1'b1);
        offer(1, 8'h11, 1'b0, got);  check("t2_acc11", 32'(got), 32'h1);
        check("t2_grant1", 32'(grant), 32'h2);
        offer(1, 8'h22, 1'b0, got);  check("t2_acc22", 32'(got), 32'h1);
        offer(1, 8'h33, 1'b1, got);  check("t2_acc33", 32'(got), 32'h1);
        req_valid[1] = 1'b0;
        check("t2_no_stray", 32'(stray), 32'd0);
        offer(2, 8'h44, 1'b1, got);  check("t2_acc44", 32'(got), 32'h1);
        req_valid[2] = 1'b0;
        wait_idle(ok);
        check("t2_idle",   32'(ok),          32'h1);
        check("t2_sent_n", 32'(sent.size()), 32'd4);
        if (sent.size() == 4) begin
            check("t2_sent0", 32'(sent[0]), 32'h11);
            check("t2_sent1", 32'(sent[1]), 32'h22);
            check("t2_sent2", 32'(sent[2]), 32'h33);
            check("t2_sent3", 32'(sent[3]), 32'h44);
        end

        // Round-robin fairness from reset with all four requesters always valid.
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_lane(i, 8'(8'hC0 + i), 1'b1);
        #1;
        for (int i = 0; i < 6; i++) begin
            wait_any(idx, busy_at);
            check($sformatf("t3_rr%0d", i), 32'(idx), 32'(i % N));
        end
        req_valid = '0;
        wait_idle(ok);
        check("t3_idle", 32'(ok), 32'h1);

        // Owner stall: req3 opens a packet, stalls 50 clocks while req0 waits.
        sent.delete();
        stray = 0;
        set_lane(0, 8'hA0, 1'b1);
        offer(3, 8'h31, 1'b0, got);  check("t4_acc31", 32'(got), 32'h1);
        req_valid[3] = 1'b0;
        launches = 0;
        rdy_seen = 0;
        repeat (50) begin
            @(negedge clk); #1;
            if (tx_byte_rdy)      launches++;
            if (req_ready != '0)  rdy_seen++;
        end
        check("t4_no_launch", 32'(launches), 32'd0);
        check("t4_no_ready",  32'(rdy_seen), 32'd0);
        check("t4_grant3",    32'(grant),    32'h8);
        offer(3, 8'h32, 1'b1, got);  check("t4_acc32", 32'(got), 32'h1);
        req_valid[3] = 1'b0;
        check("t4_no_stray", 32'(stray), 32'd0);
        offer(0, 8'hA0, 1'b1, got);  check("t4_accA0", 32'(got), 32'h1);
        req_valid[0] = 1'b0;
        wait_idle(ok);
        check("t4_sent_n", 32'(sent.size()), 32'd3);
        if (sent.size() == 3) begin
            check("t4_sent0", 32'(sent[0]), 32'h31);
            check("t4_sent1", 32'(sent[1]), 32'h32);
            check("t4_sent2", 32'(sent[2]), 32'hA0);
        end

        // Reset in the middle of a frame: no new launch until the uart goes idle.
        sent.delete();
        offer(0, 8'h5A, 1'b1, got);  check("t5_acc5A", 32'(got), 32'h1);
        req_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("t5_busy", 32'(tx_busy), 32'h1);
        set_lane(1, 8'h77, 1'b1);
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        check("t5_grant",    32'(grant),       32'h0);
        check("t5_tx_byte",  32'(tx_byte),     32'h00);
        check("t5_byte_rdy", 32'(tx_byte_rdy), 32'h0);
        check("t5_timeout",  32'(timeout),     32'h0);
        rst_n = 1'b1;
        #1;
        check("t5_ready_busy", 32'(req_ready), 32'h0);
        wait_any(idx, busy_at);
        check("t5_winner",  32'(idx),     32'd1);
        check("t5_busy_at", 32'(busy_at), 32'h0);
        req_valid[1] = 1'b0;
        wait_idle(ok);
        check("t5_sent_n", 32'(sent.size()), 32'd2);
        if (sent.size() == 2) begin
            check("t5_sent0", 32'(sent[0]), 32'h5A);
            check("t5_sent1", 32'(sent[1]), 32'h77);
        end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
        // Watchdog: uart never raises busy; timeout 16 clocks after launch.
        model_en = 1'b0;
        offer(2, 8'hE1, 1'b0, got);  check("t6_accE1", 32'(got), 32'h1);
        check("t6_launch", 32'(tx_byte_rdy), 32'h1);
        idx = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk); #1;
            if (timeout) begin
                idx = k;
                break;
            end
        end
        check("t6_timeout_at", 32'(idx), 32'd16);
        @(negedge clk); #1;
        check("t6_pulse_once", 32'(timeout), 32'h0);
        check("t6_grant",      32'(grant),   32'h0);
        set_lane(3, 8'hE3, 1'b1);
        #1;
        check("t6_ptr_adv", 32'(req_ready), 32'h8);
        req_valid = '0;
        model_en  = 1'b1;
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
